// File: rtl/mem_stage.sv
// Memory stage: issues one data-memory request per load/store, waits for the
// completion pulse, formats load data and stalls the pipeline meanwhile.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        exmem_valid,
    input  logic        exmem_mem_read,
    input  logic        exmem_mem_write,
    input  logic [2:0]  exmem_funct3,
    input  logic [31:0] exmem_alu_out,
    input  logic [31:0] exmem_rs2_out,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_mbe,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        mem_stall,
    output logic [31:0] mem_rdata,
    output logic        mem_fault
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_read;
    logic        r_write;
    logic [31:0] r_address;
    logic [31:0] r_wdata;
    logic [3:0]  r_mbe;
    logic [31:0] r_rdata;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic        r_is_load;

    logic        w_memop;
    logic        w_bad;
    logic        w_fault;
    logic        w_issue;
    logic [3:0]  w_mbe;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_fmt;

    // Decode memop, misalignment/illegal width and the issue condition
    always_comb begin
        w_memop = exmem_valid & (exmem_mem_read | exmem_mem_write);
        w_bad   = 1'b0;
        case (exmem_funct3)
            3'b000, 3'b100: w_bad = 1'b0;
            3'b001, 3'b101: w_bad = exmem_alu_out[0];
            3'b010:         w_bad = (exmem_alu_out[1:0] != 2'b00);
            default:        w_bad = 1'b1;
        endcase
        w_fault = w_memop & w_bad;
        w_issue = (r_state == S_IDLE) & w_memop & ~w_fault;
    end

    // Store lane placement; loads always request the full word
    always_comb begin
        w_mbe   = 4'b1111;
        w_wdata = exmem_rs2_out;
        if (exmem_mem_write) begin
            case (exmem_funct3[1:0])
                2'b00: begin
                    w_mbe   = 4'b0001 << exmem_alu_out[1:0];
                    w_wdata = {4{exmem_rs2_out[7:0]}};
                end
                2'b01: begin
                    w_mbe   = 4'b0011 << exmem_alu_out[1:0];
                    w_wdata = {2{exmem_rs2_out[15:0]}};
                end
                default: begin
                    w_mbe   = 4'b1111;
                    w_wdata = exmem_rs2_out;
                end
            endcase
        end
    end

    // Load formatting from the lane/width latched at issue time
    always_comb begin
        case (r_addr_lo)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_fmt = {24'd0, w_byte};
            3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_fmt = {16'd0, w_half};
            default: w_load_fmt = dmem_rdata;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_issue)   w_next = S_ACCESS;
            S_ACCESS: if (dmem_resp) w_next = S_DONE;
            S_DONE:                  w_next = S_IDLE;
            default:                 w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Request registers held through ACCESS; load result captured on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_address <= '0;
            r_wdata   <= '0;
            r_mbe     <= '0;
            r_rdata   <= '0;
            r_funct3  <= '0;
            r_addr_lo <= '0;
            r_is_load <= 1'b0;
        end else if (w_issue) begin
            r_read    <= exmem_mem_read & ~exmem_mem_write;
            r_write   <= exmem_mem_write;
            r_address <= {exmem_alu_out[31:2], 2'b00};
            r_wdata   <= w_wdata;
            r_mbe     <= w_mbe;
            r_funct3  <= exmem_funct3;
            r_addr_lo <= exmem_alu_out[1:0];
            r_is_load <= ~exmem_mem_write;
        end else if ((r_state == S_ACCESS) && dmem_resp) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            if (r_is_load) r_rdata <= w_load_fmt;
        end
    end

    // Reset also masks the combinational stall/fault so outputs drop at once
    assign mem_stall    = ~rst & ((r_state == S_ACCESS) | w_issue);
    assign mem_fault    = ~rst & (r_state == S_IDLE) & w_fault;
    assign dmem_read    = r_read;
    assign dmem_write   = r_write;
    assign dmem_address = r_address;
    assign dmem_wdata   = r_wdata;
    assign dmem_mbe     = r_mbe;
    assign mem_rdata    = r_rdata;

endmodule
